io_out_display: RTL and testbench

IO_OUT_DISPLAY -- requirements
Module: io_out_display

---
 rtl/io_out_display.sv | 184 ++++++++++++++++++
 tb/tb_io_out_display.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/io_out_display.sv
// Purpose: 4-digit multiplexed 7-segment display of the last four distinct CPU output-port values (newest on digit 0).
// Latency: 4 clk from a stable io_out_in change to the new glyph on digit 0 (2 sync flops + history + output register).
// Backpressure: none; the display scans freely and the history accepts a new value on any clk.
// Ports: clk, reset (sync, active-high); io_out_in[3:0] CPU port value;
//        seg_n[6:0] active-low segments (bit0=a .. bit6=g); dp_n active-low decimal point;
//        dig_n[3:0] active-low digit enables (bit0 = rightmost, newest value).
// Option: define IO_OUT_DISPLAY_DP_NEW_EN to light the digit-0 decimal point for DP_FRAMES
//         frames after each new value; otherwise dp_n is tied to 1.
module io_out_display #(
   parameter int SCAN_DIV  = 50000,
   parameter int DP_FRAMES = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] io_out_in,
   output logic [6:0] seg_n,
   output logic       dp_n,
   output logic [3:0] dig_n
);

   localparam int            CW       = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

   generate
      if (SCAN_DIV < 2 || SCAN_DIV > 65535 || DP_FRAMES < 1 || DP_FRAMES > 255) begin : g_bad_param
         $error("io_out_display: SCAN_DIV or DP_FRAMES out of range");
      end
   endgenerate

   // Active-high a..g glyphs, hex with lowercase b and d.
   function automatic logic [6:0] glyph(input logic [3:0] v);
      logic [6:0] g;
      g = 7'h00;
      case (v)
         4'h0: g = 7'h3F;
         4'h1: g = 7'h06;
         4'h2: g = 7'h5B;
         4'h3: g = 7'h4F;
         4'h4: g = 7'h66;
         4'h5: g = 7'h6D;
         4'h6: g = 7'h7D;
         4'h7: g = 7'h07;
         4'h8: g = 7'h7F;
         4'h9: g = 7'h6F;
         4'hA: g = 7'h77;
         4'hB: g = 7'h7C;
         4'hC: g = 7'h39;
         4'hD: g = 7'h5E;
         4'hE: g = 7'h79;
         4'hF: g = 7'h71;
         default: g = 7'h00;
      endcase
      return g;
   endfunction

   // ---------------- input synchronizer ----------------
   logic [3:0] sync1, sync2;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 4'h0;
         sync2 <= 4'h0;
      end else begin
         sync1 <= io_out_in;
         sync2 <= sync1;
      end
   end

   // ---------------- value history ----------------
   // warm counts the two edges needed to flush the synchronizer, so the
   // first capture lands on the third edge after reset and never records
   // the synchronizer's reset zero.
   logic [1:0] warm;
   logic [3:0] hist [4];
   logic [2:0] vcnt;
   logic       capture, shift, load;

   assign capture = (warm == 2'd2) && (vcnt == 3'd0);
   assign shift   = (vcnt != 3'd0) && (sync2 != hist[0]);
   assign load    = capture | shift;

   always_ff @(posedge clk) begin
      if (reset) begin
         warm <= 2'd0;
         vcnt <= 3'd0;
         for (int i = 0; i < 4; i++) hist[i] <= 4'h0;
      end else begin
         if (warm != 2'd2) warm <= warm + 2'd1;
         // On the first capture the older entries are still zero, so
         // shifting them along is harmless and keeps one load path.
         if (load) begin
            hist[3] <= hist[2];
            hist[2] <= hist[1];
            hist[1] <= hist[0];
            hist[0] <= sync2;
            if (vcnt != 3'd4) vcnt <= vcnt + 3'd1;
         end
      end
   end

   // ---------------- scan state machine ----------------
   typedef enum logic {SHOW = 1'b0, BLANK = 1'b1} scan_state_t;

   scan_state_t   state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [1:0]    idx, idx_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SHOW;
         cnt   <= '0;
         idx   <= 2'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      case (state)
         SHOW: begin
            if (cnt == CNT_LAST) state_nxt = BLANK;
            else                 cnt_nxt   = cnt + CW'(1);
         end
         BLANK: begin
            state_nxt = SHOW;
            idx_nxt   = idx + 2'd1;
            cnt_nxt   = '0;
         end
         default: state_nxt = SHOW;
      endcase
   end

   // ---------------- registered outputs ----------------
   logic [6:0] seg_d;
   logic [3:0] dig_d;

   always_comb begin
      seg_d = 7'h7F;
      dig_d = 4'hF;
      if (state == SHOW) begin
         dig_d = ~(4'b0001 << idx);
         // Digits beyond the number of captured values stay dark.
         if ({1'b0, idx} < vcnt) seg_d = ~glyph(hist[idx]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         seg_n <= 7'h7F;
         dig_n <= 4'hF;
      end else begin
         seg_n <= seg_d;
         dig_n <= dig_d;
      end
   end

`ifdef IO_OUT_DISPLAY_DP_NEW_EN
   // ---------------- new-value marker ----------------
   // A fresh load beats a same-cycle frame-wrap decrement.
   logic [7:0] mk;
   logic       wrap;

   assign wrap = (state == BLANK) && (idx == 2'd3);

   always_ff @(posedge clk) begin
      if (reset) begin
         mk   <= 8'd0;
         dp_n <= 1'b1;
      end else begin
         if (load)                     mk <= 8'(DP_FRAMES);
         else if (wrap && mk != 8'd0)  mk <= mk - 8'd1;
         dp_n <= !((state == SHOW) && (idx == 2'd0) && (mk != 8'd0));
      end
   end
`else
   assign dp_n = 1'b1;
`endif

endmodule

// File: tb/tb_io_out_display.sv
module tb_io_out_display;

   localparam int SD  = 4;
   localparam int DPF = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] io_out_in;
   logic [6:0] seg_n;
   logic       dp_n;
   logic [3:0] dig_n;

   io_out_display #(.SCAN_DIV(SD), .DP_FRAMES(DPF)) dut (
      .clk       (clk),
      .reset     (reset),
      .io_out_in (io_out_in),
      .seg_n     (seg_n),
      .dp_n      (dp_n),
      .dig_n     (dig_n)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: k = edges since reset release, the display position is
   // derived arithmetically from k, history kept as a newest-first queue.
   int k;
   int hist_q[$];
   int in_log[$];
`ifdef IO_OUT_DISPLAY_DP_NEW_EN
   int mk;
`endif
   logic [6:0] exp_seg;
   logic [3:0] exp_dig;
   logic       exp_dp;

   logic [6:0] glyph_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   task automatic model_edge(input logic r, input logic [3:0] d);
      int  p, ix, v;
      bit  show, load, wrap;
      if (r) begin
         k = 0;
         hist_q.delete();
         in_log.delete();
`ifdef IO_OUT_DISPLAY_DP_NEW_EN
         mk = 0;
`endif
         exp_seg = 7'h7F;
         exp_dig = 4'hF;
         exp_dp  = 1'b1;
         return;
      end
      k++;
      in_log.push_back(int'(d));
      // Outputs after edge k show the display position reached after edge k-1.
      p    = (k - 1) % (SD + 1);
      ix   = ((k - 1) / (SD + 1)) % 4;
      show = (p < SD);
      wrap = !show && (ix == 3);
      exp_dig = show ? ~(4'b0001 << ix) : 4'hF;
      exp_seg = (show && ix < hist_q.size()) ? ~glyph_hi[hist_q[ix]] : 7'h7F;
`ifdef IO_OUT_DISPLAY_DP_NEW_EN
      exp_dp = !(show && ix == 0 && mk != 0);
`else
      exp_dp = 1'b1;
`endif
      // History at edge k sees the input applied two edges earlier.
      load = 1'b0;
      if (k >= 3) begin
         v = in_log[k - 3];
         if (k == 3 || v != hist_q[0]) begin
            hist_q.push_front(v);
            if (hist_q.size() > 4) void'(hist_q.pop_back());
            load = 1'b1;
         end
      end
`ifdef IO_OUT_DISPLAY_DP_NEW_EN
      if (load)                mk = DPF;
      else if (wrap && mk > 0) mk = mk - 1;
`else
      if (load && wrap) begin end
`endif
   endtask

   task automatic tick(input logic r, input logic [3:0] d);
      reset     = r;
      io_out_in = d;
      @(posedge clk);
      model_edge(r, d);
      #1;
      total++;
      assert (seg_n === exp_seg) else begin
         bad++;
         $error("FAIL seg k=%0d observed=%h expected=%h", k, seg_n, exp_seg);
      end
      total++;
      assert (dig_n === exp_dig) else begin
         bad++;
         $error("FAIL dig k=%0d observed=%h expected=%h", k, dig_n, exp_dig);
      end
      total++;
      assert (dp_n === exp_dp) else begin
         bad++;
         $error("FAIL dp k=%0d observed=%b expected=%b", k, dp_n, exp_dp);
      end
   endtask

   task automatic hold(input logic [3:0] d, input int n);
      for (int i = 0; i < n; i++) tick(1'b0, d);
   endtask

   initial begin
      reset     = 1'b1;
      io_out_in = 4'h0;

      // Reset held 3 cycles with 5 on the port, then release.
      for (int i = 0; i < 3; i++) tick(1'b1, 4'h5);
      total++;
      assert (seg_n === 7'h7F && dig_n === 4'hF && dp_n === 1'b1) else begin
         bad++;
         $error("FAIL reset_out observed=%h/%h/%b expected=7f/f/1", seg_n, dig_n, dp_n);
      end
      hold(4'h5, 4);
      total++;
      assert (seg_n === 7'h12 && dig_n === 4'hE) else begin
         bad++;
         $error("FAIL first_glyph observed=%h/%h expected=12/e", seg_n, dig_n);
      end
      hold(4'h5, 20);

      // Walk 1..5, each held 20 cycles, then a full frame.
      for (int v = 1; v <= 5; v++) hold(4'(v), 20);
      hold(4'h5, 25);

      // A, A, B, A after a fresh reset: three recorded entries.
      tick(1'b1, 4'hA);
      hold(4'hA, 40);
      hold(4'hB, 20);
      hold(4'hA, 45);

      // Single-cycle reset pulse mid-scan.
      hold(4'h3, 13);
      tick(1'b1, 4'h3);
      total++;
      assert (seg_n === 7'h7F && dig_n === 4'hF) else begin
         bad++;
         $error("FAIL reset_pulse observed=%h/%h expected=7f/f", seg_n, dig_n);
      end

      // One value change, then long enough for the marker to expire.
      hold(4'h3, 30);
      hold(4'h9, 70);

      // Randomised values and hold times, with occasional resets; short holds
      // land changes on every scan phase including the BLANK entry.
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 24) == 0) tick(1'b1, 4'($urandom_range(0, 15)));
         else hold(4'($urandom_range(0, 15)), int'($urandom_range(1, 24)));
      end
      hold(4'h7, 30);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
